// File: rtl/rf_wb_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Selector width and the default data width are fixed by the 8-entry register file.
package rf_wb_queue_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int REG_SEL_W      = 3;
    localparam int NUM_REGS       = 8;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    // Entry layout at the default data width; the storage keeps the same field order.
    typedef struct packed {
        reg_sel_t                  rsel;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wb_entry_t;

    // True when a live entry targets the register a reader is asking for.
    function automatic logic sel_match(
        input logic     valid,
        input reg_sel_t ent_sel,
        input reg_sel_t rd_sel
    );
        return valid && (ent_sel == rd_sel);
    endfunction

endpackage

// File: rtl/rf_wb_fifo_mem.sv
// Entry storage for the writeback queue: two write ports, one head read port,
// and the full valid/reg/data view the forwarding search scans.
module rf_wb_fifo_mem
    import rf_wb_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr0_en,
    input  logic [PTR_W-1:0]                wr0_idx,
    input  reg_sel_t                        wr0_reg,
    input  logic [DATA_WIDTH-1:0]           wr0_data,
    input  logic                            wr1_en,
    input  logic [PTR_W-1:0]                wr1_idx,
    input  reg_sel_t                        wr1_reg,
    input  logic [DATA_WIDTH-1:0]           wr1_data,
    input  logic                            pop_en,
    input  logic [PTR_W-1:0]                pop_idx,
    input  logic [PTR_W-1:0]                rd_idx,
    output reg_sel_t                        rd_reg,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [DEPTH-1:0]                ent_valid,
    output reg_sel_t [DEPTH-1:0]            ent_reg,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data
);

    logic [DEPTH-1:0]                 valid_r;
    reg_sel_t [DEPTH-1:0]             reg_r;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_r;

    // Per-slot update; a write beats a pop of the same slot (full-depth pop+push case).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            reg_r   <= '0;
            data_r  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr0_en && (wr0_idx == PTR_W'(i))) begin
                    valid_r[i] <= 1'b1;
                    reg_r[i]   <= wr0_reg;
                    data_r[i]  <= wr0_data;
                end else if (wr1_en && (wr1_idx == PTR_W'(i))) begin
                    valid_r[i] <= 1'b1;
                    reg_r[i]   <= wr1_reg;
                    data_r[i]  <= wr1_data;
                end else if (pop_en && (pop_idx == PTR_W'(i))) begin
                    valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_reg    = reg_r[rd_idx];
    assign rd_data   = data_r[rd_idx];
    assign ent_valid = valid_r;
    assign ent_reg   = reg_r;
    assign ent_data  = data_r;

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue: arbitrates ALU (A) and memory (B) results into an in-order FIFO,
// drains one entry per cycle into the register file, and forwards pending results.
module rf_wb_queue
    import rf_wb_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [2:0]            a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [2:0]            b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic [2:0]            writeregsel,
    output logic [DATA_WIDTH-1:0] writedata,
    output logic                  write,
    input  logic [2:0]            rd1_sel,
    output logic                  rd1_hit,
    output logic [DATA_WIDTH-1:0] rd1_data,
    input  logic [2:0]            rd2_sel,
    output logic                  rd2_hit,
    output logic [DATA_WIDTH-1:0] rd2_data,
    output logic                  err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]                 count_r;
    logic [PTR_W-1:0]                 head_r;
    logic [PTR_W-1:0]                 tail_r;

    logic                             pop_s;
    logic [CNT_W-1:0]                 free_s;
    logic                             acc_a_s;
    logic                             acc_b_s;
    logic [PTR_W-1:0]                 b_idx_s;
    logic [PTR_W-1:0]                 tail_next_s;
    logic [CNT_W-1:0]                 count_next_s;
    reg_sel_t                         head_reg_s;
    logic [DATA_WIDTH-1:0]            head_data_s;
    logic [DEPTH-1:0]                 ent_valid_s;
    reg_sel_t [DEPTH-1:0]             ent_reg_s;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data_s;
    logic [DATA_WIDTH:0]              fwd1_s;
    logic [DATA_WIDTH:0]              fwd2_s;

    // Youngest live match wins: scan oldest to youngest from head, later hits overwrite.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(
        input reg_sel_t                         sel,
        input logic [PTR_W-1:0]                 head,
        input logic [DEPTH-1:0]                 valid,
        input reg_sel_t [DEPTH-1:0]             regs,
        input logic [DEPTH-1:0][DATA_WIDTH-1:0] data
    );
        logic [DATA_WIDTH:0] res;
        logic [PTR_W-1:0]    idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            res = sel_match(valid[idx], regs[idx], sel) ? {1'b1, data[idx]} : res;
        end
        return res;
    endfunction

    rf_wb_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr0_en    (acc_a_s),
        .wr0_idx   (tail_r),
        .wr0_reg   (a_reg),
        .wr0_data  (a_data),
        .wr1_en    (acc_b_s),
        .wr1_idx   (b_idx_s),
        .wr1_reg   (b_reg),
        .wr1_data  (b_data),
        .pop_en    (pop_s),
        .pop_idx   (head_r),
        .rd_idx    (head_r),
        .rd_reg    (head_reg_s),
        .rd_data   (head_data_s),
        .ent_valid (ent_valid_s),
        .ent_reg   (ent_reg_s),
        .ent_data  (ent_data_s)
    );

    // Slots usable this cycle include the one freed by the head draining at this edge.
    always_comb begin
        pop_s  = (count_r != CNT_W'(0));
        free_s = CNT_W'(DEPTH) - count_r + CNT_W'(pop_s);
    end

    // Handshake: B needs a second slot when A is also presenting, since A is enqueued first.
    always_comb begin
        a_ready = (free_s >= CNT_W'(1));
        if (a_valid) begin
            b_ready = (free_s >= CNT_W'(2));
        end else begin
            b_ready = (free_s >= CNT_W'(1));
        end
        acc_a_s = a_valid & a_ready;
        acc_b_s = b_valid & b_ready;
        err     = a_valid & b_valid & a_ready & b_ready & (a_reg == b_reg);
    end

    // Pointer and occupancy arithmetic for the next edge.
    always_comb begin
        b_idx_s      = tail_r + PTR_W'(acc_a_s);
        tail_next_s  = tail_r + PTR_W'(acc_a_s) + PTR_W'(acc_b_s);
        count_next_s = count_r - CNT_W'(pop_s) + CNT_W'(acc_a_s) + CNT_W'(acc_b_s);
    end

    // Queue control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            count_r <= count_next_s;
            head_r  <= head_r + PTR_W'(pop_s);
            tail_r  <= tail_next_s;
        end
    end

    // Register-file write port driven straight from the head entry, zero when empty.
    always_comb begin
        write = pop_s;
        if (pop_s) begin
            writeregsel = head_reg_s;
            writedata   = head_data_s;
        end else begin
            writeregsel = 3'd0;
            writedata   = '0;
        end
    end

    // Forwarding for both decode read ports.
    always_comb begin
        fwd1_s   = fwd_lookup(rd1_sel, head_r, ent_valid_s, ent_reg_s, ent_data_s);
        fwd2_s   = fwd_lookup(rd2_sel, head_r, ent_valid_s, ent_reg_s, ent_data_s);
        rd1_hit  = fwd1_s[DATA_WIDTH];
        rd1_data = fwd1_s[DATA_WIDTH-1:0];
        rd2_hit  = fwd2_s[DATA_WIDTH];
        rd2_data = fwd2_s[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: a hand-computed vector table plus model-checked
// sequences for fill/backpressure, pointer wrap and asynchronous reset.
module tb_rf_wb_queue;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0]    a_reg = 3'd0, b_reg = 3'd0, rd1_sel = 3'd0, rd2_sel = 3'd0;
    logic [DW-1:0] a_data = 16'h0000, b_data = 16'h0000;
    logic          a_ready, b_ready, write, rd1_hit, rd2_hit, err;
    logic [2:0]    writeregsel;
    logic [DW-1:0] writedata, rd1_data, rd2_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int nb_low  = 0;

    rf_wb_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .rd1_sel(rd1_sel), .rd1_hit(rd1_hit), .rd1_data(rd1_data),
        .rd2_sel(rd2_sel), .rd2_hit(rd2_hit), .rd2_data(rd2_data),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [2:0] ar; logic [15:0] ad;
        logic bv; logic [2:0] br; logic [15:0] bd;
        logic [2:0] s1; logic [2:0] s2;
        logic ew; logic [2:0] ews; logic [15:0] ewd;
        logic ear; logic ebr;
        logic eh1; logic [15:0] ed1;
        logic eh2; logic [15:0] ed2;
        logic eerr;
    } vec_t;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    vec_t vecs[14];
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic bv, input logic [2:0] br, input logic [15:0] bd,
                         input logic [2:0] s1, input logic [2:0] s2);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        rd1_sel = s1; rd2_sel = s2;
    endtask

    // One cycle checked against a behavioural in-order queue model.
    task automatic mstep(input string tag, input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic bv, input logic [2:0] br, input logic [15:0] bd, input logic [2:0] s1);
        int fr;
        logic ear, ebr, h;
        logic [15:0] fd;
        @(negedge clk);
        drive(av, ar, ad, bv, br, bd, s1, 3'd0);
        #1;
        fr  = DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
        ear = (fr >= 1);
        ebr = av ? (fr >= 2) : (fr >= 1);
        if (q.size() != 0) begin
            chk({tag, "_write"}, 32'(write), 32'd1);
            chk({tag, "_wsel"}, 32'(writeregsel), 32'(q[0].r));
            chk({tag, "_wdata"}, 32'(writedata), 32'(q[0].d));
        end else begin
            chk({tag, "_write"}, 32'(write), 32'd0);
            chk({tag, "_wdata"}, 32'(writedata), 32'd0);
        end
        chk({tag, "_a_ready"}, 32'(a_ready), 32'(ear));
        chk({tag, "_b_ready"}, 32'(b_ready), 32'(ebr));
        chk({tag, "_err"}, 32'(err), 32'(av & bv & ear & ebr & (ar == br)));
        h = 1'b0; fd = 16'h0000;
        foreach (q[i]) begin
            if (q[i].r == s1) begin h = 1'b1; fd = q[i].d; end
        end
        chk({tag, "_rd1_hit"}, 32'(rd1_hit), 32'(h));
        chk({tag, "_rd1_data"}, 32'(rd1_data), 32'(fd));
        n_acc += int'(a_valid & a_ready) + int'(b_valid & b_ready);
        if (!b_ready) nb_low++;
        if (q.size() != 0) void'(q.pop_front());
        if (av && ear) q.push_back('{ar, ad});
        if (bv && ebr) q.push_back('{br, bd});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           av ar  ad        bv br  bd        s1 s2  w ws  wd        ar br h1 d1        h2 d2        err
        vecs[0]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0};
        vecs[1]  = '{1, 3, 16'hBEEF, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0};
        vecs[2]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 5, 1, 3, 16'hBEEF, 1, 1, 1, 16'hBEEF, 0, 16'h0000, 0};
        vecs[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0};
        vecs[4]  = '{1, 5, 16'h1111, 1, 5, 16'h2222, 5, 5, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 1};
        vecs[5]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 5, 1, 5, 16'h1111, 1, 1, 1, 16'h2222, 1, 16'h2222, 0};
        vecs[6]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 0, 1, 5, 16'h2222, 1, 1, 1, 16'h2222, 0, 16'h0000, 0};
        vecs[7]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 5, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0};
        vecs[8]  = '{1, 1, 16'h00A1, 1, 2, 16'h00B2, 1, 2, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0};
        vecs[9]  = '{1, 2, 16'h0A22, 0, 0, 16'h0000, 1, 2, 1, 1, 16'h00A1, 1, 1, 1, 16'h00A1, 1, 16'h00B2, 0};
        vecs[10] = '{0, 0, 16'h0000, 1, 0, 16'h0B00, 2, 0, 1, 2, 16'h00B2, 1, 1, 1, 16'h0A22, 0, 16'h0000, 0};
        vecs[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0, 1, 2, 16'h0A22, 1, 1, 1, 16'h0A22, 1, 16'h0B00, 0};
        vecs[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7, 1, 0, 16'h0B00, 1, 1, 1, 16'h0B00, 0, 16'h0000, 0};
        vecs[13] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0};

        // Reset state while rst is held.
        #12;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_wsel", 32'(writeregsel), 32'd0);
        chk("rst_wdata", 32'(writedata), 32'd0);
        chk("rst_rd1_hit", 32'(rd1_hit), 32'd0);
        chk("rst_rd2_data", 32'(rd2_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'(i), 3'd0);
            #1;
            chk($sformatf("idle%0d_write", i), 32'(write), 32'd0);
            chk($sformatf("idle%0d_a_ready", i), 32'(a_ready), 32'd1);
            chk($sformatf("idle%0d_b_ready", i), 32'(b_ready), 32'd1);
            chk($sformatf("idle%0d_rd1_hit", i), 32'(rd1_hit), 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd,
                  vecs[i].s1, vecs[i].s2);
            #1;
            chk($sformatf("v%0d_write", i), 32'(write), 32'(vecs[i].ew));
            chk($sformatf("v%0d_wsel", i), 32'(writeregsel), 32'(vecs[i].ews));
            chk($sformatf("v%0d_wdata", i), 32'(writedata), 32'(vecs[i].ewd));
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
            chk($sformatf("v%0d_rd1_hit", i), 32'(rd1_hit), 32'(vecs[i].eh1));
            chk($sformatf("v%0d_rd1_data", i), 32'(rd1_data), 32'(vecs[i].ed1));
            chk($sformatf("v%0d_rd2_hit", i), 32'(rd2_hit), 32'(vecs[i].eh2));
            chk($sformatf("v%0d_rd2_data", i), 32'(rd2_data), 32'(vecs[i].ed2));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].eerr));
        end

        // Fill and backpressure: both ports valid every cycle for 12 cycles.
        n_acc = 0; nb_low = 0;
        for (int i = 0; i < 12; i++) begin
            mstep("fill", 1'b1, 3'(i % 8), 16'(16'h1000 + 2 * i),
                  1'b1, 3'((i + 3) % 8), 16'(16'h2001 + 2 * i), 3'(i % 8));
        end
        chk("fill_accepted", 32'(n_acc), 32'd15);
        chk("fill_b_ready_low_cycles", 32'(nb_low), 32'd9);
        for (int i = 0; i < 6; i++) begin
            mstep("fill_drain", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'(i));
        end

        // Wrap-around: 3*DEPTH single-port writes.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            mstep("wrap", 1'b1, 3'(i % 8), 16'(i), 1'b0, 3'd0, 16'h0000, 3'(i % 8));
        end
        for (int i = 0; i < 3; i++) begin
            mstep("wrap_drain", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd3);
        end

        // Asynchronous reset with three entries pending.
        mstep("rstop", 1'b1, 3'd6, 16'hAAA0, 1'b1, 3'd7, 16'hAAA1, 3'd6);
        mstep("rstop", 1'b1, 3'd6, 16'hAAA2, 1'b1, 3'd7, 16'hAAA3, 3'd6);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd7);
        #1;
        chk("rstop_pre_write", 32'(write), 32'd1);
        chk("rstop_pre_rd2_hit", 32'(rd2_hit), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rstop_write", 32'(write), 32'd0);
        chk("rstop_rd1_hit", 32'(rd1_hit), 32'd0);
        chk("rstop_rd2_hit", 32'(rd2_hit), 32'd0);
        chk("rstop_rd1_data", 32'(rd1_data), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mstep("post_rst", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
